uart_tx_buffered: RTL and testbench

- Buffered UART transmitter driving the CPU's `serial_out` pin; the output counterpart of the CPU's UART receive path on `serial_in`.
- Accepts bytes from the memory-mapped UART TX register through a ready/valid handshake and queues them in a small FIFO.
- Serializes them as 8N1 frames at a fixed baud rate.
- Lets software and the BIOS issue back-to-back writes without polling after every byte.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_buffered_if.sv | 9 +
 rtl/uart_tx_serializer.sv | 116 +++++++++++
 rtl/uart_tx_buffered.sv | 81 ++++++++
 tb/tb_uart_tx_buffered.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int FRAME_BITS = 10;

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Bits needed to hold SYMBOL_EDGE_TIME-1; never narrower than one bit.
    function automatic int baud_cnt_width(input int clock_freq, input int baud_rate);
        int set_v;
        set_v = clock_freq / baud_rate;
        if (set_v < 2) begin
            return 1;
        end else begin
            return $clog2(set_v);
        end
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte producer handshake into the transmit queue.
interface uart_tx_buffered_if;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;

    modport master (output data_in, output data_in_valid, input data_in_ready);
    modport slave  (input data_in, input data_in_valid, output data_in_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 frame serializer: pulls bytes from the queue head and shifts them out LSB first.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] head_data,
    input  logic       head_valid,
    output logic       head_ready,
    output logic       serial_out,
    output logic       busy
);

    localparam int SET = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CW  = baud_cnt_width(CLOCK_FREQ, BAUD_RATE);
    localparam logic [CW-1:0] BAUD_LAST = CW'(SET - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(FRAME_BITS - 3);

    tx_state_e     state_r, state_s;
    logic [CW-1:0] baud_cnt_r, baud_cnt_s;
    logic [2:0]    bit_cnt_r, bit_cnt_s;
    logic [7:0]    shift_r, shift_s;
    logic          line_r, line_s;
    logic          pop_s;
    logic          bit_end_s;

    assign bit_end_s = (baud_cnt_r == BAUD_LAST);

    // Next-state, baud timing and line value for the frame sequencer
    always_comb begin
        state_s    = state_r;
        baud_cnt_s = bit_end_s ? {CW{1'b0}} : (baud_cnt_r + CW'(1));
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        line_s     = line_r;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                baud_cnt_s = {CW{1'b0}};
                if (head_valid) begin
                    pop_s   = 1'b1;
                    shift_s = head_data;
                    line_s  = 1'b0;
                    state_s = START;
                end else begin
                    line_s  = 1'b1;
                end
            end
            START: begin
                if (bit_end_s) begin
                    line_s    = shift_r[0];
                    shift_s   = {1'b0, shift_r[7:1]};
                    bit_cnt_s = 3'd0;
                    state_s   = DATA;
                end else begin
                    state_s   = START;
                end
            end
            DATA: begin
                if (bit_end_s && (bit_cnt_r == LAST_BIT)) begin
                    line_s  = 1'b1;
                    state_s = STOP;
                end else if (bit_end_s) begin
                    line_s    = shift_r[0];
                    shift_s   = {1'b0, shift_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                end else begin
                    state_s   = DATA;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when a byte is waiting
                if (bit_end_s && head_valid) begin
                    pop_s   = 1'b1;
                    shift_s = head_data;
                    line_s  = 1'b0;
                    state_s = START;
                end else if (bit_end_s) begin
                    line_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                line_s  = 1'b1;
                state_s = IDLE;
            end
        endcase
    end

    // Serializer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            baud_cnt_r <= {CW{1'b0}};
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            line_r     <= 1'b1;
        end else begin
            state_r    <= state_s;
            baud_cnt_r <= baud_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            line_r     <= line_s;
        end
    end

    assign head_ready = pop_s;
    assign serial_out = line_r;
    assign busy       = (state_r != IDLE);

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte queue in front of an 8N1 serializer.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    uart_tx_buffered_if.slave               in_if,
    output logic                            serial_out,
    output logic                            tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r, count_s;
    logic             ready_s, push_s, pop_s, head_valid_s, ser_busy_s;

    assign ready_s      = (count_r != FULL_COUNT);
    assign push_s       = in_if.data_in_valid && ready_s;
    assign head_valid_s = (count_r != {CNT_W{1'b0}});

    // Queue occupancy after this cycle's push/pop
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_W'(1);
            2'b01:   count_s = count_r - CNT_W'(1);
            default: count_s = count_r;
        endcase
    end

    // Queue pointers and count; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_s;
        end
    end

    // Byte storage; contents are don't-care until the count covers them
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_if.data_in;
        end
    end

    uart_tx_serializer #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .head_data  (mem_r[rd_ptr_r]),
        .head_valid (head_valid_s),
        .head_ready (pop_s),
        .serial_out (serial_out),
        .busy       (ser_busy_s)
    );

    assign in_if.data_in_ready = ready_s;
    assign fifo_count          = count_r;
    assign tx_busy             = ser_busy_s || head_valid_s;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed self-checking bench for uart_tx_buffered with a mid-bit sampling line decoder.
module tb_uart_tx_buffered;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 37_000;
    localparam int SET    = CLK_HZ / BAUD;   // 27 cycles per bit
    localparam int FRAME  = 10 * SET;
    localparam int DEPTH  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_out;
    logic       tx_busy;
    logic [3:0] fifo_count;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    logic [9:0] rx_frames [$];
    int         rx_start [$];

    uart_tx_buffered_if bus ();

    uart_tx_buffered #(
        .CLOCK_FREQ (CLK_HZ),
        .BAUD_RATE  (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (bus),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: detect start, sample each bit at its middle, drop frames cut by reset
    initial begin : rx_mon
        bit         act;
        int         cnt;
        int         idx;
        logic [9:0] fr;
        act = 1'b0;
        cnt = 0;
        fr  = 10'h000;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 1'b0;
            end else if (!act) begin
                if (serial_out === 1'b0) begin
                    act = 1'b1;
                    cnt = 0;
                    rx_start.push_back(cyc);
                end
            end else begin
                cnt++;
                if ((cnt % SET) == (SET / 2)) begin
                    idx = cnt / SET;
                    fr[idx] = serial_out;
                    if (idx == 9) begin
                        rx_frames.push_back(fr);
                        act = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        wait (cyc > 50000);
        $display("FAIL watchdog cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] fexp(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic wait_frames(input int n, input int budget, input string tag);
        int w;
        w = 0;
        while (rx_frames.size() < n && w < budget) begin
            tick(1);
            w++;
        end
        check(tag, rx_frames.size(), n);
    endtask

    task automatic clear_rx();
        rx_frames.delete();
        rx_start.delete();
    endtask

    initial begin : main
        int         e;
        int         idx;
        bit         rdy;
        int         acc [12];

        bus.data_in       = 8'h00;
        bus.data_in_valid = 1'b0;
        rst = 1'b1;
        tick(3);
        check("rst_serial", serial_out, 1);
        check("rst_ready", bus.data_in_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_count", fifo_count, 0);
        rst = 1'b0;
        tick(2);

        // Single byte 0xA5
        bus.data_in = 8'hA5;
        bus.data_in_valid = 1'b1;
        tick(1);                       // edge N
        bus.data_in_valid = 1'b0;
        bus.data_in = 8'h00;
        check("single_cnt_n", fifo_count, 1);
        check("single_line_n", serial_out, 1);
        check("single_busy_n", tx_busy, 1);
        tick(1);                       // edge N+1
        check("single_start", serial_out, 0);
        check("single_cnt_n1", fifo_count, 0);
        tick(FRAME - 1);               // edge N+FRAME
        check("single_busy_end", tx_busy, 1);
        check("single_stop", serial_out, 1);
        tick(1);                       // edge N+1+FRAME
        check("single_idle", tx_busy, 0);
        wait_frames(1, 5, "single_nframes");
        check("single_frame", rx_frames[0], fexp(8'hA5));
        tick(SET);
        check("single_line_high", serial_out, 1);

        // Back-to-back 0x00, 0xFF
        clear_rx();
        bus.data_in = 8'h00;
        bus.data_in_valid = 1'b1;
        tick(1);
        bus.data_in = 8'hFF;
        tick(1);
        bus.data_in_valid = 1'b0;
        wait_frames(2, 2 * FRAME + 50, "b2b_nframes");
        check("b2b_frame0", rx_frames[0], fexp(8'h00));
        check("b2b_frame1", rx_frames[1], fexp(8'hFF));
        check("b2b_gap", rx_start[1] - rx_start[0], FRAME);
        tick(SET);
        check("b2b_idle", tx_busy, 0);

        // Fill and stall: 12 bytes, garbage on data_in whenever ready is low
        clear_rx();
        e = 0;
        idx = 0;
        while (idx < 12 && e < 4 * FRAME) begin
            rdy = bus.data_in_ready;
            bus.data_in = rdy ? 8'(8'h30 + idx) : (8'hC0 ^ e[7:0]);
            bus.data_in_valid = 1'b1;
            tick(1);                   // edge e
            if (rdy) begin
                acc[idx] = e;
                idx++;
            end
            if (e == 8) begin
                check("fill_count8", fifo_count, 8);
                check("fill_ready_low", bus.data_in_ready, 0);
            end
            if (e == FRAME / 2) check("stall_count", fifo_count, 8);
            if (e == FRAME) check("stall_ready_low", bus.data_in_ready, 0);
            if (e == FRAME + 1) check("stall_ready_high", bus.data_in_ready, 1);
            e++;
        end
        bus.data_in_valid = 1'b0;
        check("fill_all_accepted", idx, 12);
        for (int k = 0; k < 9; k++) check($sformatf("fill_acc%0d", k), acc[k], k);
        check("fill_acc9", acc[9], FRAME + 2);
        check("fill_acc11", acc[11], 3 * FRAME + 2);
        wait_frames(12, 12 * FRAME, "fill_nframes");
        for (int k = 0; k < 12; k++) check($sformatf("fill_frame%0d", k), rx_frames[k], fexp(8'(8'h30 + k)));
        tick(SET);

        // Wrap-around: 20 bytes 0x00..0x13 with continuous valid
        clear_rx();
        e = 0;
        idx = 0;
        while (idx < 20 && e < 25 * FRAME) begin
            rdy = bus.data_in_ready;
            bus.data_in = 8'(idx);
            bus.data_in_valid = 1'b1;
            tick(1);
            if (rdy) idx++;
            e++;
        end
        bus.data_in_valid = 1'b0;
        check("wrap_all_accepted", idx, 20);
        wait_frames(20, 20 * FRAME, "wrap_nframes");
        for (int k = 0; k < 20; k++) check($sformatf("wrap_frame%0d", k), rx_frames[k], fexp(8'(k)));
        tick(SET);

        // Reset during data bit 3 with 3 bytes queued
        clear_rx();
        bus.data_in_valid = 1'b1;
        bus.data_in = 8'h35; tick(1);  // edge 0
        bus.data_in = 8'h11; tick(1);  // edge 1: 0x35 popped
        bus.data_in = 8'h22; tick(1);
        bus.data_in = 8'h33; tick(1);  // edge 3
        bus.data_in_valid = 1'b0;
        tick(4 * SET);                 // inside bit 3 period of 0x35
        check("rstmid_bit3", serial_out, 0);
        check("rstmid_queued", fifo_count, 3);
        rst = 1'b1;
        tick(1);
        check("rstmid_line", serial_out, 1);
        check("rstmid_count", fifo_count, 0);
        check("rstmid_ready", bus.data_in_ready, 1);
        check("rstmid_busy", tx_busy, 0);
        rst = 1'b0;
        tick(2);
        clear_rx();
        bus.data_in = 8'h5A;
        bus.data_in_valid = 1'b1;
        tick(1);
        bus.data_in_valid = 1'b0;
        wait_frames(1, FRAME + 50, "post_rst_nframes");
        check("post_rst_frame", rx_frames[0], fexp(8'h5A));
        tick(FRAME + SET);
        check("post_rst_only_one", rx_frames.size(), 1);
        check("post_rst_idle", tx_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
